// File: rtl/prio_encoder_stream_if.sv
// Request/index stream bundle for prio_encoder_stream.
//   i, i_load          : request vector and its load strobe (into the encoder)
//   y, y_valid, y_ready: emitted index with valid/ready handshake
//   busy, ovf          : pending-set status and duplicate-load pulse (from the encoder)
//   y_last             : only when PRIO_ENC_LAST_EN is defined; marks the final index of a burst
// Modports: slave = encoder side, master = producer/consumer side.
interface prio_encoder_stream_if #(
    parameter int unsigned N = 4
) ();
    localparam int unsigned W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0] i;
    logic         i_load;
    logic [W-1:0] y;
    logic         y_valid;
    logic         y_ready;
    logic         busy;
    logic         ovf;
`ifdef PRIO_ENC_LAST_EN
    logic         y_last;

    modport slave  (input  i, i_load, y_ready, output y, y_valid, busy, ovf, y_last);
    modport master (output i, i_load, y_ready, input  y, y_valid, busy, ovf, y_last);
`else
    modport slave  (input  i, i_load, y_ready, output y, y_valid, busy, ovf);
    modport master (output i, i_load, y_ready, input  y, y_valid, busy, ovf);
`endif
endinterface

// File: rtl/prio_encoder_stream.sv
// prio_encoder_stream: sequential priority encoder. Request bits are merged into a
// sticky pending set and emitted one index per accepted transfer on a valid/ready port.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : prio_encoder_stream_if.slave (i, i_load, y, y_valid, y_ready, busy, ovf[, y_last])
// Parameters:
//   N         : number of request inputs (>= 1)
//   MSB_FIRST : 1 = highest set index wins, 0 = lowest set index wins
// Optional feature: define PRIO_ENC_LAST_EN to add y_last, set when the emitted index
// left nothing else pending at the moment it was taken.
module prio_encoder_stream #(
    parameter int unsigned N         = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    prio_encoder_stream_if.slave  bus
);
    localparam int unsigned W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0] pending_q, pending_d;
    logic [N-1:0] eff;
    logic [N-1:0] sel_oh;
    logic [W-1:0] sel;
    logic [W-1:0] y_q, y_d;
    logic         y_valid_q, y_valid_d;
    logic         ovf_q, ovf_d;
    logic         slot_free;
    logic         take;
`ifdef PRIO_ENC_LAST_EN
    logic         y_last_q, y_last_d;
`endif

    // Candidate set: pending bits plus whatever is loaded this cycle.
    always_comb begin
        eff       = pending_q | (bus.i_load ? bus.i : '0);
        slot_free = !y_valid_q || bus.y_ready;
        take      = slot_free && (eff != '0);
    end

    // Priority pick; the last hit in loop order wins.
    always_comb begin
        sel    = '0;
        sel_oh = '0;
        if (MSB_FIRST) begin
            for (int k = 0; k < int'(N); k++) begin
                if (eff[k]) begin
                    sel       = W'(k);
                    sel_oh    = '0;
                    sel_oh[k] = 1'b1;
                end
            end
        end else begin
            for (int k = int'(N) - 1; k >= 0; k--) begin
                if (eff[k]) begin
                    sel       = W'(k);
                    sel_oh    = '0;
                    sel_oh[k] = 1'b1;
                end
            end
        end
    end

    // Next-state: clear the taken bit, hold y while stalled.
    always_comb begin
        pending_d = eff & ~(take ? sel_oh : '0);
        y_d       = y_q;
        y_valid_d = y_valid_q;
        ovf_d     = bus.i_load && (|(bus.i & pending_q));
`ifdef PRIO_ENC_LAST_EN
        y_last_d  = y_last_q;
`endif
        if (take) begin
            y_d       = sel;
            y_valid_d = 1'b1;
`ifdef PRIO_ENC_LAST_EN
            y_last_d  = ((eff & ~sel_oh) == '0);
`endif
        end else if (y_valid_q && bus.y_ready) begin
            y_valid_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef PRIO_ENC_LAST_EN
            y_last_q  <= 1'b0;
`endif
        end else begin
            pending_q <= pending_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            ovf_q     <= ovf_d;
`ifdef PRIO_ENC_LAST_EN
            y_last_q  <= y_last_d;
`endif
        end
    end

    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;
    assign bus.ovf     = ovf_q;
    assign bus.busy    = |pending_q;
`ifdef PRIO_ENC_LAST_EN
    assign bus.y_last  = y_last_q;
`endif

endmodule

// File: tb/tb_prio_encoder_stream.sv
// Bench for prio_encoder_stream: two encoders (MSB-first and LSB-first, N=4) share
// identical stimulus; a set-level reference model predicts emitted indices into
// scoreboard queues, a negedge monitor pops them on each accepted transfer.
module tb_prio_encoder_stream;
    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prio_encoder_stream_if #(.N(N)) bus0 ();
    prio_encoder_stream_if #(.N(N)) bus1 ();

    prio_encoder_stream #(.N(N), .MSB_FIRST(1'b1)) dut_msb (.clk(clk), .rst(rst), .bus(bus0));
    prio_encoder_stream #(.N(N), .MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .rst(rst), .bus(bus1));

    int n_chk  = 0;
    int n_fail = 0;
    int n_pops = 0;

    // Reference model state (value after the most recent edge), index 0 = MSB-first.
    logic [3:0] m_pend [2];
    bit         m_yv   [2];
    int         m_y    [2];
    bit         m_ovf  [2];
    bit         m_last [2];
    int         q0 [$];
    int         q1 [$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Highest or lowest set bit position, from plain integer arithmetic.
    function automatic int pick(input logic [3:0] e, input bit msb);
        int v;
        v = int'(e);
        if (msb) return $clog2(v + 1) - 1;
        return $clog2(v & -v);
    endfunction

    // Drive one cycle of inputs, advance the model, then check registered outputs.
    task automatic step(input bit r, input logic [3:0] iv, input bit ld, input bit rdy);
        logic [3:0] eff;
        int         idx;
        int         exp_item;
        int         a_yv [2];
        int         a_y  [2];
        int         a_bz [2];
        int         a_ov [2];
        int         a_ls [2];
        rst          = r;
        bus0.i       = iv;  bus1.i       = iv;
        bus0.i_load  = ld;  bus1.i_load  = ld;
        bus0.y_ready = rdy; bus1.y_ready = rdy;
        for (int d = 0; d < 2; d++) begin
            if (r) begin
                m_pend[d] = '0; m_yv[d] = 1'b0; m_y[d] = 0; m_ovf[d] = 1'b0; m_last[d] = 1'b0;
                if (d == 0) q0.delete(); else q1.delete();
            end else begin
                eff      = m_pend[d] | (ld ? iv : 4'b0000);
                m_ovf[d] = ld && ((iv & m_pend[d]) != 4'b0000);
                if ((!m_yv[d] || rdy) && eff != 4'b0000) begin
                    idx       = pick(eff, d == 0);
                    m_pend[d] = eff & ~(4'b0001 << idx);
                    m_yv[d]   = 1'b1;
                    m_y[d]    = idx;
                    m_last[d] = (m_pend[d] == 4'b0000);
                    exp_item  = idx * 2 + int'(m_last[d]);
                    if (d == 0) q0.push_back(exp_item); else q1.push_back(exp_item);
                end else begin
                    m_pend[d] = eff;
                    if (m_yv[d] && rdy) m_yv[d] = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        a_yv[0] = int'(bus0.y_valid); a_yv[1] = int'(bus1.y_valid);
        a_y[0]  = int'(bus0.y);       a_y[1]  = int'(bus1.y);
        a_bz[0] = int'(bus0.busy);    a_bz[1] = int'(bus1.busy);
        a_ov[0] = int'(bus0.ovf);     a_ov[1] = int'(bus1.ovf);
`ifdef PRIO_ENC_LAST_EN
        a_ls[0] = int'(bus0.y_last);  a_ls[1] = int'(bus1.y_last);
`else
        a_ls[0] = 0; a_ls[1] = 0;
`endif
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("y_valid[%0d]", d), a_yv[d], int'(m_yv[d]));
            chk($sformatf("y[%0d]", d), a_y[d], m_y[d]);
            chk($sformatf("busy[%0d]", d), a_bz[d], int'(m_pend[d] != 4'b0000));
            chk($sformatf("ovf[%0d]", d), a_ov[d], int'(m_ovf[d]));
`ifdef PRIO_ENC_LAST_EN
            chk($sformatf("y_last[%0d]", d), a_ls[d], int'(m_last[d]));
`endif
        end
    endtask

    // Monitor: every accepted transfer must match the oldest predicted index.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus0.y_valid === 1'b1 && bus0.y_ready === 1'b1) begin
                n_pops++;
                if (q0.size() == 0) chk("unexpected_emit_msb", int'(bus0.y), -1);
                else begin
                    int e;
                    e = q0.pop_front();
                    chk("emit_idx_msb", int'(bus0.y), e / 2);
`ifdef PRIO_ENC_LAST_EN
                    chk("emit_last_msb", int'(bus0.y_last), e % 2);
`endif
                end
            end
            if (bus1.y_valid === 1'b1 && bus1.y_ready === 1'b1) begin
                n_pops++;
                if (q1.size() == 0) chk("unexpected_emit_lsb", int'(bus1.y), -1);
                else begin
                    int e;
                    e = q1.pop_front();
                    chk("emit_idx_lsb", int'(bus1.y), e / 2);
`ifdef PRIO_ENC_LAST_EN
                    chk("emit_last_lsb", int'(bus1.y_last), e % 2);
`endif
                end
            end
        end
    end

    initial begin
        // Reset for two cycles.
        step(1, 4'b0000, 0, 0);
        step(1, 4'b0000, 0, 0);
        // Full burst with consumer always ready.
        step(0, 4'b1111, 1, 1);
        repeat (5) step(0, 4'b0000, 0, 1);
        // Backpressure, then release.
        step(0, 4'b0101, 1, 0);
        repeat (3) step(0, 4'b0000, 0, 0);
        repeat (3) step(0, 4'b0000, 0, 1);
        // Duplicate load while pending, then release.
        step(0, 4'b0110, 1, 0);
        step(0, 4'b0010, 1, 0);
        step(0, 4'b0000, 0, 0);
        repeat (4) step(0, 4'b0000, 0, 1);
        // Reload of the index currently held in y: no ovf, emitted again.
        step(0, 4'b0100, 1, 0);
        step(0, 4'b0100, 1, 0);
        repeat (4) step(0, 4'b0000, 0, 1);
        // Reset in the middle of a burst; reset cycle also ignores a load.
        step(0, 4'b1111, 1, 1);
        step(1, 4'b1111, 1, 1);
        repeat (3) step(0, 4'b0000, 0, 1);
        // Sparse pattern, empty load, and load concurrent with accept.
        step(0, 4'b1010, 1, 1);
        repeat (3) step(0, 4'b0000, 0, 1);
        step(0, 4'b0000, 1, 1);
        step(0, 4'b1001, 1, 1);
        step(0, 4'b0110, 1, 1);
        repeat (5) step(0, 4'b0000, 0, 1);
        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 59) == 0), 4'($urandom), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 3) != 0));
        end
        // Drain and confirm nothing predicted was left unemitted.
        repeat (10) step(0, 4'b0000, 0, 1);
        chk("drain_msb", q0.size(), 0);
        chk("drain_lsb", q1.size(), 0);
        chk("enough_transfers", int'(n_pops >= 100), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
